// File: rtl/shift_add_mul16_if.sv
// rtl/shift_add_mul16_if.sv - operand/product handshakes and adder operand bus for shift_add_mul16
interface shift_add_mul16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;

    modport slave (
        input  in_valid, mcand, mplier, out_ready, add_s, add_cout,
        output in_ready, out_valid, product, busy, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, mcand, mplier, out_ready, add_s, add_cout,
        input  in_ready, out_valid, product, busy, add_a, add_b, add_cin
    );
endinterface

// File: rtl/shift_add_mul16.sv
// rtl/shift_add_mul16.sv - 16x16 unsigned shift-and-add multiplier driving an external 16-bit adder
module shift_add_mul16 #(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_add_mul16_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SC_LAST = 4'(SETTLE - 1);

    state_t      state;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [15:0] mc;
    logic [3:0]  iter;
    logic [3:0]  sc;

    // Operands are pure functions of registers so they hold still for the whole settle window.
    assign bus.add_a     = (state == ADD) ? hi : 16'h0000;
    assign bus.add_b     = ((state == ADD) && lo[0]) ? mc : 16'h0000;
    assign bus.add_cin   = 1'b0;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ADD);
    assign bus.product   = {hi, lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= 16'h0000;
            lo    <= 16'h0000;
            mc    <= 16'h0000;
            iter  <= 4'd0;
            sc    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mc    <= bus.mcand;
                        lo    <= bus.mplier;
                        hi    <= 16'h0000;
                        iter  <= 4'd0;
                        sc    <= 4'd0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (sc == SC_LAST) begin
                        // {cout,sum,lo} shifted right by one: carry lands in hi[15], sum[0] in lo[15].
                        hi   <= {bus.add_cout, bus.add_s[15:1]};
                        lo   <= {bus.add_s[0], lo[15:1]};
                        sc   <= 4'd0;
                        iter <= iter + 4'd1;
                        if (iter == 4'd15) begin
                            state <= DONE;
                        end
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mul16.sv
// tb/tb_shift_add_mul16.sv - randomized self-checking bench for shift_add_mul16 (SETTLE=1 and SETTLE=3)
module tb_shift_add_mul16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int settle_of [2] = '{1, 3};

    logic [1:0]  iv = 2'b00;
    logic [1:0]  ordy = 2'b00;
    logic [15:0] mca [2];
    logic [15:0] mpl [2];
    logic [1:0]  ir, ov, bs;
    logic [31:0] pr [2];

    shift_add_mul16_if ifa ();
    shift_add_mul16_if ifb ();

    shift_add_mul16 #(.SETTLE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    shift_add_mul16 #(.SETTLE(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    assign ifa.in_valid  = iv[0];
    assign ifa.out_ready = ordy[0];
    assign ifa.mcand     = mca[0];
    assign ifa.mplier    = mpl[0];
    assign ifb.in_valid  = iv[1];
    assign ifb.out_ready = ordy[1];
    assign ifb.mcand     = mca[1];
    assign ifb.mplier    = mpl[1];
    assign ir = {ifb.in_ready, ifa.in_ready};
    assign ov = {ifb.out_valid, ifa.out_valid};
    assign bs = {ifb.busy, ifa.busy};
    assign pr[0] = ifa.product;
    assign pr[1] = ifb.product;

    // Ideal adder for the SETTLE=1 instance.
    assign {ifa.add_cout, ifa.add_s} = 17'(ifa.add_a) + 17'(ifa.add_b) + 17'(ifa.add_cin);

    // Slow adder for SETTLE=3: result is wrong until operands have been stable for two edges.
    logic [31:0] last_ops;
    logic        stab;
    logic        b_ok;
    logic [16:0] b_sum;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ops <= 32'h0;
            stab     <= 1'b1;
        end else if ({ifb.add_a, ifb.add_b} != last_ops) begin
            last_ops <= {ifb.add_a, ifb.add_b};
            stab     <= 1'b0;
        end else begin
            stab <= 1'b1;
        end
    end
    assign b_ok  = stab && ({ifb.add_a, ifb.add_b} == last_ops);
    assign b_sum = 17'(ifb.add_a) + 17'(ifb.add_b) + 17'(ifb.add_cin);
    assign {ifb.add_cout, ifb.add_s} = b_ok ? b_sum : ~b_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input string tag);
        logic [31:0] exp;
        logic [31:0] pv;
        int n, lat, bc, chg;
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        mca[s] = a;
        mpl[s] = b;
        iv[s]  = 1'b1;
        n = 0;
        while (!ir[s] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 32'(ir[s]), 32'd1);
        @(negedge clk);
        iv[s] = 1'b0;
        lat = 0; bc = 0; chg = 0; pv = pr[s];
        while (!ov[s] && lat < 200) begin
            if (bs[s]) bc++;
            if (pr[s] != pv) chg++;
            pv = pr[s];
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(16 * settle_of[s]));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(16 * settle_of[s]));
        check({tag, "_product"}, pr[s], exp);
        if (s == 1) check({tag, "_step_changes_le16"}, 32'(chg <= 16), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                mca[s] = 16'($urandom);
                mpl[s] = 16'($urandom);
                iv[s]  = 1'b1;
            end else begin
                iv[s] = 1'b0;
            end
            @(negedge clk);
            check({tag, "_bp_valid"}, 32'(ov[s]), 32'd1);
            check({tag, "_bp_product"}, pr[s], exp);
            check({tag, "_bp_in_ready"}, 32'(ir[s]), 32'd0);
        end
        iv[s]   = 1'b0;
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        check({tag, "_post_valid"}, 32'(ov[s]), 32'd0);
        check({tag, "_post_in_ready"}, 32'(ir[s]), 32'd1);
    endtask

    initial begin
        int cnt;
        mca[0] = '0; mpl[0] = '0; mca[1] = '0; mpl[1] = '0;
        #12;
        check("rst_in_ready", 32'(ir[0]), 32'd1);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_busy", 32'(bs[0]), 32'd0);
        check("rst_product", pr[0], 32'd0);
        check("rst_add_ops", {ifa.add_a, ifa.add_b}, 32'd0);
        check("rst_add_cin", 32'(ifa.add_cin), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 16'd3, 16'd5, 0, "3x5");
        run_op(0, 16'hFFFF, 16'hFFFF, 0, "ffff_sq");
        run_op(0, 16'h1234, 16'h0000, 0, "zero_mplier");
        run_op(0, 16'h00FF, 16'h0100, 10, "backpressure");
        run_op(1, 16'hABCD, 16'h0003, 2, "settle3");
        run_op(1, 16'hFFFF, 16'hFFFF, 0, "settle3_ffff");

        // Abort an operation midway through with an asynchronous reset.
        @(negedge clk);
        mca[0] = 16'h8000; mpl[0] = 16'h8000; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_before", 32'(bs[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(ir[0]), 32'd1);
        check("abort_out_valid", 32'(ov[0]), 32'd0);
        check("abort_busy", 32'(bs[0]), 32'd0);
        check("abort_product", pr[0], 32'd0);
        check("abort_add_ops", {ifa.add_a, ifa.add_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) cnt++;
        end
        ordy[0] = 1'b0;
        check("abort_no_valid", 32'(cnt), 32'd0);
        run_op(0, 16'd2, 16'd2, 0, "after_abort");

        for (int i = 0; i < 20; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), $urandom_range(0, 3), "rnd1");
        end
        for (int i = 0; i < 4; i++) begin
            run_op(1, 16'($urandom), 16'($urandom), $urandom_range(0, 2), "rnd3");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
